// File: rtl/ex_stage_reg_pkg.sv
// rtl/ex_stage_reg_pkg.sv - shared types and constants for the decode->execute pipeline register
package ex_stage_reg_pkg;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       valid;
    logic       mode_rv;
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
  } ctrl_e_t;

  // Bubble keeps cond at AL so condcheck never sees an undefined cond field
  localparam ctrl_e_t BUBBLE_CTRL = '{
    valid:      1'b0,
    mode_rv:    1'b0,
    cond:       COND_AL,
    flag_write: 2'b00,
    pcsrc:      1'b0,
    regwrite:   1'b0,
    memwrite:   1'b0,
    branch:     1'b0,
    jump:       1'b0
  };

  function automatic ctrl_e_t make_bubble(input logic mode_rv);
    ctrl_e_t c;
    c         = BUBBLE_CTRL;
    c.mode_rv = mode_rv;
    return c;
  endfunction

endpackage

// File: rtl/ex_stage_reg_if.sv
// rtl/ex_stage_reg_if.sv - decode-side inputs and execute-side outputs of the E pipeline register
interface ex_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);

  logic             valid_d;
  logic             mode_rv_d;
  logic [3:0]       cond_d;
  logic [1:0]       flag_write_d;
  logic             pcsrc_d;
  logic             regwrite_d;
  logic             memwrite_d;
  logic             branch_d;
  logic             jump_d;
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;
  logic [WIDTH-1:0] ext_imm_d;
  logic [WIDTH-1:0] pc_d;
  logic [RADDR-1:0] wa3_d;
  logic [3:0]       flags_d;

  logic             valid_e;
  logic             mode_rv_e;
  logic [3:0]       cond_e;
  logic [1:0]       flag_write_e;
  logic             pcsrc_e;
  logic             regwrite_e;
  logic             memwrite_e;
  logic             branch_e;
  logic             jump_e;
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;
  logic [WIDTH-1:0] ext_imm_e;
  logic [WIDTH-1:0] pc_e;
  logic [RADDR-1:0] wa3_e;
  logic [3:0]       flags_e;

  modport master (
    output valid_d, mode_rv_d, cond_d, flag_write_d, pcsrc_d, regwrite_d,
           memwrite_d, branch_d, jump_d, rd1_d, rd2_d, ext_imm_d, pc_d,
           wa3_d, flags_d,
    input  valid_e, mode_rv_e, cond_e, flag_write_e, pcsrc_e, regwrite_e,
           memwrite_e, branch_e, jump_e, rd1_e, rd2_e, ext_imm_e, pc_e,
           wa3_e, flags_e
  );

  modport slave (
    input  valid_d, mode_rv_d, cond_d, flag_write_d, pcsrc_d, regwrite_d,
           memwrite_d, branch_d, jump_d, rd1_d, rd2_d, ext_imm_d, pc_d,
           wa3_d, flags_d,
    output valid_e, mode_rv_e, cond_e, flag_write_e, pcsrc_e, regwrite_e,
           memwrite_e, branch_e, jump_e, rd1_e, rd2_e, ext_imm_e, pc_e,
           wa3_e, flags_e
  );

endinterface

// File: rtl/ex_stage_reg_flopenrc_n.sv
// rtl/ex_stage_reg_flopenrc_n.sv - flop with async active-low reset, enable and sync clear
module flopenrc_n #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Sync clear returns to the reset value and wins over the enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RST_VAL;
    end else if (clr_i) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ex_stage_reg.sv
// rtl/ex_stage_reg.sv - decode->execute pipeline register with NZCV flags and bubble counter
module ex_stage_reg #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_e_i,
  input  logic               flush_e_i,
  input  logic               cnt_clr_i,
  ex_stage_reg_if.slave      pipe,
  output logic [CNT_W-1:0]   bubble_cnt_o
);
  import ex_stage_reg_pkg::*;

  localparam int DW = 4 * WIDTH + RADDR;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             bubble_in;
  ctrl_e_t          ctrl_d;
  ctrl_e_t          ctrl_q;
  logic             ctrl_en;
  logic [DW-1:0]    data_d;
  logic [DW-1:0]    data_q;
  logic             flags_en;
  logic [3:0]       flags_q;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign bubble_in = flush_e_i | ~pipe.valid_d;

  // Mode tracks decode even for bubbles so the flags gate follows the stream
  always_comb begin
    ctrl_d = '{
      valid:      1'b1,
      mode_rv:    pipe.mode_rv_d,
      cond:       pipe.cond_d,
      flag_write: pipe.flag_write_d,
      pcsrc:      pipe.pcsrc_d,
      regwrite:   pipe.regwrite_d,
      memwrite:   pipe.memwrite_d,
      branch:     pipe.branch_d,
      jump:       pipe.jump_d
    };
    if (bubble_in) begin
      ctrl_d = make_bubble(pipe.mode_rv_d);
    end
  end

  assign ctrl_en = flush_e_i | ~stall_e_i;

  flopenrc_n #(.W($bits(ctrl_e_t)), .RST_VAL(BUBBLE_CTRL)) u_ctrl (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (ctrl_en),
    .clr_i (1'b0),
    .d_i   (ctrl_d),
    .q_o   (ctrl_q)
  );

  assign data_d = {pipe.rd1_d, pipe.rd2_d, pipe.ext_imm_d, pipe.pc_d, pipe.wa3_d};

  flopenrc_n #(.W(DW)) u_data (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (~stall_e_i),
    .clr_i (1'b0),
    .d_i   (data_d),
    .q_o   (data_q)
  );

  // Flags follow the instruction currently in E; RISC-V ops never touch NZCV
  assign flags_en = ~stall_e_i & ~ctrl_q.mode_rv;

  flopenrc_n #(.W(4)) u_flags (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (flags_en),
    .clr_i (1'b0),
    .d_i   (pipe.flags_d),
    .q_o   (flags_q)
  );

  assign cnt_d  = cnt_q + CNT_W'(1);
  assign cnt_en = ~stall_e_i & bubble_in & (cnt_q != CNT_MAX);

  flopenrc_n #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .en_i  (cnt_en),
    .clr_i (cnt_clr_i),
    .d_i   (cnt_d),
    .q_o   (cnt_q)
  );

  assign pipe.valid_e      = ctrl_q.valid;
  assign pipe.mode_rv_e    = ctrl_q.mode_rv;
  assign pipe.cond_e       = ctrl_q.cond;
  assign pipe.flag_write_e = ctrl_q.flag_write;
  assign pipe.pcsrc_e      = ctrl_q.pcsrc;
  assign pipe.regwrite_e   = ctrl_q.regwrite;
  assign pipe.memwrite_e   = ctrl_q.memwrite;
  assign pipe.branch_e     = ctrl_q.branch;
  assign pipe.jump_e       = ctrl_q.jump;

  assign {pipe.rd1_e, pipe.rd2_e, pipe.ext_imm_e, pipe.pc_e, pipe.wa3_e} = data_q;

  assign pipe.flags_e = flags_q;
  assign bubble_cnt_o = cnt_q;

endmodule
